// File: rtl/lfsr_cascade_counter_pkg.sv
// Shared constants and constant functions for the LFSR cascade counter.
// Latency: none (compile-time only).
// Backpressure: not applicable.
package lfsr_cascade_counter_pkg;

  localparam int DEF_LFSR_W = 3;
  localparam int DEF_BIN_W  = 5;

  // Maximal-length right-shift Galois feedback masks for widths 2..16.
  function automatic logic [15:0] max_taps(input int w);
    logic [15:0] t;
    t = 16'h0000;
    case (w)
      2:  t = 16'h0003;
      3:  t = 16'h0006;
      4:  t = 16'h000C;
      5:  t = 16'h0014;
      6:  t = 16'h0030;
      7:  t = 16'h0060;
      8:  t = 16'h00B8;
      9:  t = 16'h0110;
      10: t = 16'h0240;
      11: t = 16'h0500;
      12: t = 16'h0E08;
      13: t = 16'h1C80;
      14: t = 16'h3802;
      15: t = 16'h6000;
      16: t = 16'hB400;
      default: t = 16'h0000;
    endcase
    return t;
  endfunction

  // Inverse Galois step. The top tap is always set, so the MSB of the
  // successor tells whether the predecessor's LSB was 1.
  function automatic logic [15:0] lfsr_prev(input logic [15:0] s,
                                            input logic [15:0] taps,
                                            input int          w);
    logic        b0;
    logic [15:0] t;
    logic [15:0] mask;
    mask = 16'((32'd1 << w) - 32'd1);
    b0   = s[4'(w - 1)];
    t    = s ^ (b0 ? taps : 16'h0000);
    return ((t << 1) | {15'h0000, b0}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_cascade_counter_if.sv
// Control and status bundle of the cascade counter.
// Latency: wires only.
// Backpressure: none; every enabled cycle is consumed.
interface lfsr_cascade_counter_if
  import lfsr_cascade_counter_pkg::*;
#(
  parameter int LFSR_W = DEF_LFSR_W,
  parameter int BIN_W  = DEF_BIN_W
);
  logic                    en;
  logic                    clr;
  logic                    load;
  logic [LFSR_W-1:0]       load_lfsr;
  logic [BIN_W-1:0]        load_bin;
  logic [BIN_W+LFSR_W-1:0] q;
  logic                    carry;
  logic                    tc;
  logic                    wrap;
  logic                    load_err;

  modport master (
    output en, clr, load, load_lfsr, load_bin,
    input  q, carry, tc, wrap, load_err
  );

  modport slave (
    input  en, clr, load, load_lfsr, load_bin,
    output q, carry, tc, wrap, load_err
  );
endinterface

// File: rtl/lfsr_cascade_counter_lfsr.sv
// Maximal-length right-shift Galois LFSR with clear, load and zero-seed guard.
// Latency: 1 clk from en/load/clr to state.
// Backpressure: none; steps on every enabled cycle.
module galois_lfsr
  import lfsr_cascade_counter_pkg::*;
#(
  parameter int                LFSR_W = 3,
  parameter logic [LFSR_W-1:0] TAPS   = 3'b110,
  parameter logic [LFSR_W-1:0] SEED   = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              en,
  output logic [LFSR_W-1:0] state,
  output logic              carry,
  output logic              last
);
  // Predecessor of SEED: the state whose step wraps the sequence.
  localparam logic [LFSR_W-1:0] LAST =
    LFSR_W'(lfsr_prev(16'(SEED), 16'(TAPS), LFSR_W));

  logic [LFSR_W-1:0] nxt;

  assign nxt   = (state >> 1) ^ (state[0] ? TAPS : '0);
  assign last  = (state == LAST);
  assign carry = en & last;

  // State register; a zero load is replaced by SEED so the lock-up state is never entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       state <= SEED;
    else if (clr)  state <= SEED;
    else if (load) state <= (load_val == '0) ? SEED : load_val;
    else if (en)   state <= nxt;
  end
endmodule

// File: rtl/lfsr_cascade_counter.sv
// Two-stage event counter: Galois LFSR low stage, binary high stage on LFSR wrap.
// Latency: 1 clk to q/wrap/load_err; carry and tc are combinational decodes.
// Backpressure: none; en is sampled every cycle, SATURATE holds at terminal count.
module lfsr_cascade_counter
  import lfsr_cascade_counter_pkg::*;
#(
  parameter int                LFSR_W   = 3,
  parameter logic [LFSR_W-1:0] TAPS     = LFSR_W'(max_taps(LFSR_W)),
  parameter logic [LFSR_W-1:0] SEED     = '1,
  parameter int                BIN_W    = 5,
  parameter bit                SATURATE = 1'b0
) (
  input logic                   clk,
  input logic                   rst,
  lfsr_cascade_counter_if.slave bus
);
  logic [BIN_W-1:0]  bin_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_last;
  logic              lfsr_carry;
  logic              tc;
  logic              step_en;

  assign tc = lfsr_last & (bin_q == '1);
  // In saturate mode the low stage freezes at terminal count, which also kills carry.
  assign step_en = bus.en & ~(SATURATE & tc);

  galois_lfsr #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.clr),
    .load     (bus.load),
    .load_val (bus.load_lfsr),
    .en       (step_en),
    .state    (lfsr_q),
    .carry    (lfsr_carry),
    .last     (lfsr_last)
  );

  // Binary high stage advances on the same edge the LFSR wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            bin_q <= '0;
    else if (bus.clr)   bin_q <= '0;
    else if (bus.load)  bin_q <= bus.load_bin;
    else if (lfsr_carry) bin_q <= bin_q + 1'b1;
  end

  // One-cycle status pulses; clr and load discard the count step, so no wrap then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wrap     <= 1'b0;
      bus.load_err <= 1'b0;
    end else begin
      bus.wrap     <= ~bus.clr & ~bus.load & bus.en & tc;
      bus.load_err <= ~bus.clr & bus.load & (bus.load_lfsr == '0);
    end
  end

  assign bus.q     = {bin_q, lfsr_q};
  assign bus.carry = lfsr_carry;
  assign bus.tc    = tc;
endmodule

// File: tb/tb_lfsr_cascade_counter.sv
// Directed bench for lfsr_cascade_counter: default wrap mode, saturate mode, 5-bit LFSR.
// Latency: checks registered outputs 1 ns after the rising edge, comb outputs before it.
// Backpressure: not applicable.
module tb_lfsr_cascade_counter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  lfsr_cascade_counter_if #(.LFSR_W(3), .BIN_W(5)) ba ();
  lfsr_cascade_counter_if #(.LFSR_W(3), .BIN_W(5)) bs ();
  lfsr_cascade_counter_if #(.LFSR_W(5), .BIN_W(5)) bw ();

  lfsr_cascade_counter #(.SATURATE(1'b0)) u_wrap (.clk(clk), .rst(rst), .bus(ba));
  lfsr_cascade_counter #(.SATURATE(1'b1)) u_sat  (.clk(clk), .rst(rst), .bus(bs));
  lfsr_cascade_counter #(.LFSR_W(5), .TAPS(5'b10100), .BIN_W(5)) u_w5 (.clk(clk), .rst(rst), .bus(bw));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0]  seq [8];
    logic [4:0]  s5;
    logic [31:0] seen;
    int          dup;

    seq = '{3'b111, 3'b101, 3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b111};
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b1;
    ba.en = 0; ba.clr = 0; ba.load = 0; ba.load_lfsr = '0; ba.load_bin = '0;
    bs.en = 0; bs.clr = 0; bs.load = 0; bs.load_lfsr = '0; bs.load_bin = '0;
    bw.en = 0; bw.clr = 0; bw.load = 0; bw.load_lfsr = '0; bw.load_bin = '0;
    tick();
    tick();
    chk("reset_q", 64'(ba.q), 64'h07);
    chk("reset_wrap", 64'(ba.wrap), 64'h0);
    chk("reset_load_err", 64'(ba.load_err), 64'h0);
    rst = 1'b0;
    tick();
    chk("idle_q", 64'(ba.q), 64'h07);

    // first LFSR period; carry only in the seventh cycle
    ba.en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("seq_carry", 64'(ba.carry), 64'(i == 6));
      tick();
      chk("seq_lfsr", 64'(ba.q[2:0]), 64'(seq[i+1]));
    end
    chk("first_carry_bin", 64'(ba.q), 64'h0F);

    // run to terminal count (223 steps total), then wrap
    for (int i = 0; i < 216; i++) tick();
    chk("tc_set", 64'(ba.tc), 64'h1);
    chk("tc_q", 64'(ba.q), 64'hFB);
    chk("tc_carry", 64'(ba.carry), 64'h1);
    tick();
    chk("wrap_q", 64'(ba.q), 64'h07);
    chk("wrap_pulse", 64'(ba.wrap), 64'h1);
    chk("wrap_tc_clear", 64'(ba.tc), 64'h0);
    ba.en = 1'b0;
    tick();
    chk("wrap_drop", 64'(ba.wrap), 64'h0);
    chk("hold_q", 64'(ba.q), 64'h07);

    // zero-seed load with en: seed substituted, no step, error pulse
    ba.load = 1'b1; ba.load_lfsr = 3'b000; ba.load_bin = 5'd9; ba.en = 1'b1;
    tick();
    chk("zload_q", 64'(ba.q), 64'h4F);
    chk("zload_err", 64'(ba.load_err), 64'h1);
    ba.load = 1'b0; ba.en = 1'b0;
    tick();
    chk("zload_err_drop", 64'(ba.load_err), 64'h0);
    chk("zload_hold", 64'(ba.q), 64'h4F);

    // normal load to {4, 100}
    ba.load = 1'b1; ba.load_lfsr = 3'b100; ba.load_bin = 5'd4;
    tick();
    chk("load_q", 64'(ba.q), 64'h24);
    chk("load_no_err", 64'(ba.load_err), 64'h0);
    ba.load = 1'b0;

    // asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_q", 64'(ba.q), 64'h07);
    rst = 1'b0;
    tick();
    chk("post_rst_q", 64'(ba.q), 64'h07);

    // clear with en discards the step
    ba.en = 1'b1;
    tick(); tick(); tick();
    chk("pre_clr_q", 64'(ba.q), 64'h02);
    ba.clr = 1'b1;
    tick();
    chk("clr_q", 64'(ba.q), 64'h07);
    chk("clr_no_wrap", 64'(ba.wrap), 64'h0);
    ba.clr = 1'b0; ba.en = 1'b0;

    // saturate mode: hold at terminal count, wrap every cycle, carry suppressed
    bs.en = 1'b1;
    for (int i = 0; i < 223; i++) tick();
    chk("sat_tc", 64'(bs.tc), 64'h1);
    chk("sat_tc_q", 64'(bs.q), 64'hFB);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("sat_carry", 64'(bs.carry), 64'h0);
      tick();
      chk("sat_hold_q", 64'(bs.q), 64'hFB);
      chk("sat_wrap", 64'(bs.wrap), 64'h1);
    end
    bs.en = 1'b0;
    tick();
    chk("sat_wrap_drop", 64'(bs.wrap), 64'h0);

    // 5-bit LFSR: 31 distinct nonzero states per carry
    s5   = 5'b11111;
    seen = '0;
    dup  = 0;
    bw.en = 1'b1;
    for (int i = 0; i < 31; i++) begin
      #1;
      chk("w5_carry", 64'(bw.carry), 64'(i == 30));
      tick();
      s5 = (s5 >> 1) ^ (s5[0] ? 5'b10100 : 5'b00000);
      chk("w5_state", 64'(bw.q[4:0]), 64'(s5));
      if (seen[bw.q[4:0]]) dup++;
      seen[bw.q[4:0]] = 1'b1;
    end
    bw.en = 1'b0;
    chk("w5_no_dup", 64'(dup), 64'h0);
    chk("w5_distinct", 64'($countones(seen)), 64'd31);
    chk("w5_no_zero", 64'(seen[0]), 64'h0);
    chk("w5_q", 64'(bw.q), 64'h3F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
